// File: rtl/nrisc_fetch_seq.sv
// Fetch sequencer: registered program counter, instruction register and a call/return stack with sticky errors.
// Optional macro NRISC_FETCH_OVF_TRAP_EN redirects an overflowing call to TRAP_VECTOR instead of the call target.
module nrisc_fetch_seq #(
    parameter int             TAM          = 16,
    parameter int             NSTACK       = 8,
    parameter logic [TAM-1:0] RESET_VECTOR = '0,
    parameter logic [TAM-1:0] TRAP_VECTOR  = 16'hFFF0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_ready,
    input  logic [TAM-1:0]              instr_in,
    input  logic [1:0]                  pc_ctrl,
    input  logic                        call,
    input  logic [TAM-1:0]              target,
    input  logic [2:0]                  flags_in,
    output logic [TAM-1:0]              ProgADDR,
    output logic [TAM-1:0]              instr_out,
    output logic                        instr_valid,
    output logic [2:0]                  flags_out,
    output logic [$clog2(NSTACK+1)-1:0] stack_depth,
    output logic [1:0]                  stack_err
);

    localparam int DW = $clog2(NSTACK + 1);
    localparam int AW = $clog2(NSTACK);

    logic [TAM-1:0] r_pc;
    logic [TAM-1:0] r_instr;
    logic           r_valid;
    logic [2:0]     r_flags;
    logic [DW-1:0]  r_depth;
    logic [1:0]     r_err;
    logic [TAM-1:0] r_stk_pc [NSTACK];
    logic [2:0]     r_stk_fl [NSTACK];

    logic [TAM-1:0] w_pc_inc;
    logic [TAM-1:0] w_next_pc;
    logic [DW-1:0]  w_next_depth;
    logic [2:0]     w_next_flags;
    logic           w_push;
    logic [1:0]     w_err_new;
    logic           w_full;
    logic           w_empty;
    logic [DW-1:0]  w_depth_dec;
    logic [AW-1:0]  w_push_idx;
    logic [AW-1:0]  w_pop_idx;

    assign w_pc_inc    = r_pc + {{(TAM-1){1'b0}}, 1'b1};
    assign w_full      = (r_depth == DW'(NSTACK));
    assign w_empty     = (r_depth == {DW{1'b0}});
    assign w_depth_dec = r_depth - {{(DW-1){1'b0}}, 1'b1};
    assign w_push_idx  = r_depth[AW-1:0];
    assign w_pop_idx   = w_depth_dec[AW-1:0];

    // Next program address, stack movement and new error bits for a ready cycle
    always_comb begin
        w_next_pc    = r_pc;
        w_next_depth = r_depth;
        w_next_flags = r_flags;
        w_push       = 1'b0;
        w_err_new    = 2'b00;
        case (pc_ctrl)
            2'b00: w_next_pc = w_pc_inc;
            2'b01: w_next_pc = r_pc;
            2'b10: begin
                if (call) begin
                    if (w_full) begin
                        w_err_new[0] = 1'b1;
`ifdef NRISC_FETCH_OVF_TRAP_EN
                        w_next_pc    = TRAP_VECTOR;
`else
                        w_next_pc    = target;
`endif
                    end else begin
                        w_push       = 1'b1;
                        w_next_depth = r_depth + {{(DW-1){1'b0}}, 1'b1};
                        w_next_pc    = target;
                    end
                end else begin
                    w_next_pc = target;
                end
            end
            2'b11: begin
                // An empty-stack return behaves as a plain increment
                if (w_empty) begin
                    w_err_new[1] = 1'b1;
                    w_next_pc    = w_pc_inc;
                end else begin
                    w_next_pc    = r_stk_pc[w_pop_idx];
                    w_next_flags = r_stk_fl[w_pop_idx];
                    w_next_depth = w_depth_dec;
                end
            end
            default: w_next_pc = r_pc;
        endcase
    end

    // Architectural state: PC, instruction register, flags, depth and sticky errors
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_VECTOR;
            r_instr <= {TAM{1'b0}};
            r_valid <= 1'b0;
            r_flags <= 3'b000;
            r_depth <= {DW{1'b0}};
            r_err   <= 2'b00;
        end else begin
            r_valid <= mem_ready;
            if (mem_ready) begin
                r_instr <= instr_in;
                r_pc    <= w_next_pc;
                r_flags <= w_next_flags;
                r_depth <= w_next_depth;
                r_err   <= r_err | w_err_new;
            end else begin
                r_instr <= r_instr;
            end
        end
    end

    // Return-stack storage; slots above the depth are never read
    always_ff @(posedge clk) begin
        if (!rst && mem_ready && w_push) begin
            r_stk_pc[w_push_idx] <= w_pc_inc;
            r_stk_fl[w_push_idx] <= flags_in;
        end else begin
            r_stk_pc[w_push_idx] <= r_stk_pc[w_push_idx];
        end
    end

    assign ProgADDR    = r_pc;
    assign instr_out   = r_instr;
    assign instr_valid = r_valid;
    assign flags_out   = r_flags;
    assign stack_depth = r_depth;
    assign stack_err   = r_err;

endmodule

// File: tb/tb_nrisc_fetch_seq.sv
// Scoreboard bench for nrisc_fetch_seq: a queue-based reference model predicts every cycle's outputs.
module tb_nrisc_fetch_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_ready = 1'b0;
    logic [15:0] instr_in = 16'h0000;
    logic [1:0]  pc_ctrl = 2'b00;
    logic        call = 1'b0;
    logic [15:0] target = 16'h0000;
    logic [2:0]  flags_in = 3'b000;
    logic [15:0] ProgADDR;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [2:0]  flags_out;
    logic [3:0]  stack_depth;
    logic [1:0]  stack_err;

    nrisc_fetch_seq dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .instr_in(instr_in),
        .pc_ctrl(pc_ctrl), .call(call), .target(target), .flags_in(flags_in),
        .ProgADDR(ProgADDR), .instr_out(instr_out), .instr_valid(instr_valid),
        .flags_out(flags_out), .stack_depth(stack_depth), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        valid;
        logic [2:0]  fl;
        logic [3:0]  depth;
        logic [1:0]  err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;

    // Reference model state: the return stack is a plain queue of {return pc, flags}
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic        m_valid;
    logic [2:0]  m_fl;
    logic [1:0]  m_err;
    logic [18:0] m_stack[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic mr, input logic [1:0] ctl, input logic c,
                        input logic [15:0] tgt, input logic [2:0] fl);
        exp_t e;
        logic [18:0] top;
        @(negedge clk);
        rst = r; mem_ready = mr; pc_ctrl = ctl; call = c; target = tgt; flags_in = fl;
        instr_in = 16'($urandom);
        if (r) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_valid = 1'b0; m_fl = 3'b000;
            m_err = 2'b00; m_stack.delete();
        end else begin
            m_valid = mr;
            if (mr) begin
                m_instr = instr_in;
                if (ctl == 2'b00) begin
                    m_pc = m_pc + 16'h0001;
                end else if (ctl == 2'b10 && c && m_stack.size() == 8) begin
                    m_err[0] = 1'b1;
`ifdef NRISC_FETCH_OVF_TRAP_EN
                    m_pc = 16'hFFF0;
`else
                    m_pc = tgt;
`endif
                end else if (ctl == 2'b10 && c) begin
                    m_stack.push_back({m_pc + 16'h0001, fl});
                    m_pc = tgt;
                end else if (ctl == 2'b10) begin
                    m_pc = tgt;
                end else if (ctl == 2'b11 && m_stack.size() == 0) begin
                    m_err[1] = 1'b1;
                    m_pc = m_pc + 16'h0001;
                end else if (ctl == 2'b11) begin
                    top = m_stack.pop_back();
                    m_pc = top[18:3];
                    m_fl = top[2:0];
                end
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.valid = m_valid; e.fl = m_fl;
        e.depth = 4'(m_stack.size()); e.err = m_err;
        sb_q.push_back(e);
    endtask

    // Monitor: one expected record per clock edge, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("ProgADDR", ProgADDR, e.pc);
                check("instr_out", instr_out, e.instr);
                check("instr_valid", {15'd0, instr_valid}, {15'd0, e.valid});
                check("flags_out", {13'd0, flags_out}, {13'd0, e.fl});
                check("stack_depth", {12'd0, stack_depth}, {12'd0, e.depth});
                check("stack_err", {14'd0, stack_err}, {14'd0, e.err});
            end
        end
    end

    initial begin
        logic [1:0] ctl;
        // Reset then sequential fetch
        step(1'b1, 1'b1, 2'b10, 1'b1, 16'h1234, 3'b111);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 3'b000);
        // Call from 0010 to 0200 and return
        step(1'b0, 1'b1, 2'b10, 1'b0, 16'h0010, 3'b000);
        step(1'b0, 1'b1, 2'b10, 1'b1, 16'h0200, 3'b101);
        step(1'b0, 1'b1, 2'b01, 1'b1, 16'h0000, 3'b000);
        step(1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 3'b000);
        // Stall with a pending jump, then resume
        step(1'b0, 1'b0, 2'b10, 1'b1, 16'h0400, 3'b010);
        step(1'b0, 1'b0, 2'b10, 1'b0, 16'h0400, 3'b010);
        step(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 3'b000);
        // Nine calls overflow, then unwind with one underflow
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 2'b10, 1'b1, 16'h0100, 3'(i));
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 3'b000);
        // Empty-stack return at FFFF wraps to 0000
        step(1'b1, 1'b1, 2'b00, 1'b0, 16'h0000, 3'b000);
        step(1'b0, 1'b1, 2'b10, 1'b0, 16'hFFFF, 3'b000);
        step(1'b0, 1'b1, 2'b11, 1'b0, 16'h0000, 3'b000);
        // Reset during a call at depth 3
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b10, 1'b1, 16'(16'h0300 + i), 3'b110);
        step(1'b1, 1'b1, 2'b10, 1'b1, 16'h0500, 3'b011);
        step(1'b0, 1'b1, 2'b00, 1'b0, 16'h0000, 3'b000);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ctl = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                 ctl, 1'($urandom), 16'($urandom), 3'($urandom));
        end
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 16'(sb_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nrisc_fetch_seq.md
NRISC_FETCH_SEQ -- requirements
Module: nrisc_fetch_seq

Interface
REQ-001 SHALL provide parameter TAM, default 16, giving the address and instruction width in bits.
REQ-002 SHALL provide parameter NSTACK, default 8, giving the return-stack depth in entries (>=2).
REQ-003 SHALL provide parameter RESET_VECTOR, default 0, giving the PC value loaded at reset.
REQ-004 SHALL provide parameter TRAP_VECTOR, default 16'hFFF0, giving the overflow trap target (used only under REQ-027).
REQ-005 SHALL have a single clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-006 Ports SHALL be:
 clk  in  1  system clock
 rst  in  1  synchronous active-high reset
 mem_ready  in  1  program memory holds valid data for ProgADDR
 instr_in  in  TAM  program memory read data
 pc_ctrl  in  2  00 increment, 01 hold, 10 jump, 11 return
 call  in  1  with pc_ctrl=10: push return context
 target  in  TAM  jump/call destination
 flags_in  in  3  ULA flags to save on call
 ProgADDR  out  TAM  current program address (registered)
 instr_out  out  TAM  instruction register
 instr_valid  out  1  instr_out captured this cycle
 flags_out  out  3  flags restored by last return
 stack_depth  out  $clog2(NSTACK+1)  occupied entries
 stack_err  out  2  bit0 overflow, bit1 underflow, sticky

Function
REQ-007 Cycle with mem_ready=0 SHALL hold ProgADDR, instr_out, flags_out, stack and stack_depth, and SHALL drive instr_valid=0 next cycle; pc_ctrl/call ignored.
REQ-008 Cycle with mem_ready=1 SHALL capture instr_in into instr_out, set instr_valid=1, and update ProgADDR per REQ-009..REQ-013 (1-cycle latency).
REQ-009 pc_ctrl=00: ProgADDR <= ProgADDR+1, modulo 2^TAM (FFFF -> 0000 at TAM=16).
REQ-010 pc_ctrl=01: ProgADDR unchanged.
REQ-011 pc_ctrl=10, call=0: ProgADDR <= target; stack unchanged.
REQ-012 pc_ctrl=10, call=1, stack not full: push {ProgADDR+1 (wrapped), flags_in}; stack_depth+1; ProgADDR <= target.
REQ-013 pc_ctrl=11, stack not empty: ProgADDR <= top PC; flags_out <= top flags; stack_depth-1.
REQ-014 call SHALL be ignored unless pc_ctrl=10.
REQ-015 Call with stack_depth=NSTACK: no push, depth unchanged, stack_err[0] <= 1; ProgADDR per REQ-027.
REQ-016 Return with stack_depth=0: no pop, flags_out unchanged, stack_err[1] <= 1, ProgADDR <= ProgADDR+1.
REQ-017 stack_err bits SHALL remain set until reset; concurrent new errors OR in.
REQ-018 Stack SHALL be LIFO; entries beyond stack_depth are don't-care and never observable.
REQ-019 flags_out SHALL change only on a successful return or reset.

Reset
REQ-020 rst=1 at a clock edge SHALL set ProgADDR=RESET_VECTOR, instr_out=0, instr_valid=0, flags_out=0, stack_depth=0, stack_err=0.
REQ-021 Reset SHALL override mem_ready and pc_ctrl in the same cycle, discarding any in-flight call/return.
REQ-022 First cycle after reset release with mem_ready=1 SHALL capture instruction at RESET_VECTOR.

Configuration
REQ-027 Macro NRISC_FETCH_OVF_TRAP_EN: when defined, overflowing call SHALL set ProgADDR <= TRAP_VECTOR; when undefined, overflowing call SHALL set ProgADDR <= target (jump taken, return lost). stack_err[0] behaviour identical in both.

Verification
REQ-030 Reset then 3 cycles pc_ctrl=00, mem_ready=1 -> ProgADDR 0,1,2,3; instr_valid 0 then 1; instr_out tracks instr_in.
REQ-031 At ProgADDR=0010, pc_ctrl=10, call=1, target=0200, flags_in=101; later pc_ctrl=11 -> ProgADDR 0200, depth 1; then ProgADDR 0011, flags_out=101, depth 0.
REQ-032 mem_ready=0 for 2 cycles with pc_ctrl=10, target=0400 -> ProgADDR, depth unchanged, instr_valid=0; resume with pc_ctrl=00 -> ProgADDR+1.
REQ-033 NSTACK=8, 9 consecutive calls to 0100 -> depth 8, stack_err=01, ProgADDR=0100 (macro off) or FFF0 (macro on); 8 returns unwind in LIFO order.
REQ-034 Return at depth 0 from ProgADDR=FFFF -> ProgADDR=0000, stack_err=10, flags_out unchanged.
REQ-035 Assert rst during a call cycle at depth 3 -> ProgADDR=RESET_VECTOR, depth 0, stack_err=00, flags_out=000 next cycle.
